// File: rtl/pc_seq_unit.sv
// pc_seq_unit: registered program counter with fetch handshake,
// trap redirect, halt/resume, misalign detection and retire counter.
module pc_seq_unit #(
    parameter int unsigned PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     fetch_valid_o,
    input  logic                     fetch_ready_i,
    output logic [PC_WIDTH-1:0]      pc_o,
    input  logic                     exec_valid_i,
    input  logic                     stall_i,
    input  logic                     jal_i,
    input  logic                     jalr_i,
    input  logic                     branch_i,
    input  logic                     branch_jump_i,
    input  logic [PC_WIDTH-1:0]      imm_i,
    input  logic [PC_WIDTH-1:0]      jalr_rs1_rdata_i,
    input  logic                     trap_i,
    input  logic [PC_WIDTH-1:0]      trap_vec_i,
    input  logic                     halt_i,
    input  logic                     resume_i,
    output logic                     redirect_o,
    output logic                     misalign_o,
    output logic [PC_WIDTH-1:0]      misalign_addr_o,
    output logic [INSTRET_WIDTH-1:0] instret_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
        ~PC_WIDTH'((1 << ALIGN_BITS) - 1);

    state_t                   state_q, state_d;
    logic                     boot_q;
    logic                     fetch_valid_q, fetch_valid_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic                     redirect_q, redirect_d;
    logic                     misalign_q, misalign_d;
    logic [PC_WIDTH-1:0]      maddr_q, maddr_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic                     trap_take;
    logic                     retire;
    logic                     jump_taken;
    logic                     misaligned;
    logic                     ret_mis;
    logic                     ret_jmp;
    logic                     ret_seq;
    logic [PC_WIDTH-1:0]      seq_pc;
    logic [PC_WIDTH-1:0]      br_tgt;
    logic [PC_WIDTH-1:0]      jalr_sum;
    logic [PC_WIDTH-1:0]      tgt;

    // PC only moves on retire or trap, so a stalled fetch needs no gating.
    logic unused_fetch_ready;
    assign unused_fetch_ready = fetch_ready_i;

    assign trap_take  = trap_i && (state_q != IDLE);
    assign retire     = (state_q == RUN) && exec_valid_i
                        && !stall_i && !trap_take;
    assign jump_taken = jal_i | jalr_i | (branch_i & branch_jump_i);

    assign seq_pc   = pc_q + PC_WIDTH'(4);
    assign br_tgt   = pc_q + imm_i;
    assign jalr_sum = jalr_rs1_rdata_i + imm_i;

    // Select jump target: jalr is register-relative with bit 0 cleared.
    always_comb begin
        tgt = br_tgt;
        if (jalr_i) begin
            tgt = {jalr_sum[PC_WIDTH-1:1], 1'b0};
        end
    end

    assign misaligned = jump_taken && (tgt[ALIGN_BITS-1:0] != '0);
    assign ret_mis    = retire && misaligned;
    assign ret_jmp    = retire && jump_taken && !misaligned;
    assign ret_seq    = retire && !jump_taken;

    // Next-state logic; IDLE dwells until the boot flag is set so
    // fetch starts on the second edge after reset release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (boot_q) begin
                    state_d = halt_i ? HALT : RUN;
                end
            end
            RUN: begin
                if (!trap_take && halt_i) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (trap_take || resume_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        fetch_valid_d = (state_d == RUN);
    end

    // Datapath update: trap, misaligned jump, jump, or sequential retire.
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        maddr_d    = maddr_q;
        instret_d  = instret_q;
        unique case (1'b1)
            trap_take: begin
                pc_d       = trap_vec_i & ALIGN_MASK;
                redirect_d = 1'b1;
            end
            ret_mis: begin
                misalign_d = 1'b1;
                maddr_d    = tgt;
            end
            ret_jmp: begin
                pc_d       = tgt;
                redirect_d = 1'b1;
                instret_d  = instret_q + INSTRET_WIDTH'(1);
            end
            ret_seq: begin
                pc_d      = seq_pc;
                instret_d = instret_q + INSTRET_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            boot_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            pc_q          <= RESET_PC;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
            maddr_q       <= '0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            boot_q        <= 1'b1;
            fetch_valid_q <= fetch_valid_d;
            pc_q          <= pc_d;
            redirect_q    <= redirect_d;
            misalign_q    <= misalign_d;
            maddr_q       <= maddr_d;
            instret_q     <= instret_d;
        end
    end

    assign fetch_valid_o   = fetch_valid_q;
    assign pc_o            = pc_q;
    assign redirect_o      = redirect_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = maddr_q;
    assign instret_o       = instret_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed bench for pc_seq_unit, one instance with
// ALIGN_BITS=2 (a) and one with ALIGN_BITS=1 (b) sharing inputs.
module tb_pc_seq_unit;

    logic        clk;
    logic        rst;
    logic        fetch_ready;
    logic        exec_valid;
    logic        stall;
    logic        jal;
    logic        jalr;
    logic        branch;
    logic        branch_jump;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap;
    logic [31:0] trap_vec;
    logic        halt;
    logic        resume;

    logic        fv_a, fv_b;
    logic [31:0] pc_a, pc_b;
    logic        red_a, red_b;
    logic        mis_a, mis_b;
    logic [31:0] maddr_a, maddr_b;
    logic [63:0] ir_a, ir_b;

    int tests;
    int fails;

    pc_seq_unit #(
        .PC_WIDTH(32), .RESET_PC(32'h8000_0000),
        .ALIGN_BITS(2), .INSTRET_WIDTH(64)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_o(fv_a), .fetch_ready_i(fetch_ready),
        .pc_o(pc_a), .exec_valid_i(exec_valid), .stall_i(stall),
        .jal_i(jal), .jalr_i(jalr), .branch_i(branch),
        .branch_jump_i(branch_jump), .imm_i(imm),
        .jalr_rs1_rdata_i(rs1), .trap_i(trap), .trap_vec_i(trap_vec),
        .halt_i(halt), .resume_i(resume),
        .redirect_o(red_a), .misalign_o(mis_a),
        .misalign_addr_o(maddr_a), .instret_o(ir_a)
    );

    pc_seq_unit #(
        .PC_WIDTH(32), .RESET_PC(32'h8000_0000),
        .ALIGN_BITS(1), .INSTRET_WIDTH(64)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_o(fv_b), .fetch_ready_i(fetch_ready),
        .pc_o(pc_b), .exec_valid_i(exec_valid), .stall_i(stall),
        .jal_i(jal), .jalr_i(jalr), .branch_i(branch),
        .branch_jump_i(branch_jump), .imm_i(imm),
        .jalr_rs1_rdata_i(rs1), .trap_i(trap), .trap_vec_i(trap_vec),
        .halt_i(halt), .resume_i(resume),
        .redirect_o(red_b), .misalign_o(mis_b),
        .misalign_addr_o(maddr_b), .instret_o(ir_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        exec_valid  = 1'b0;
        stall       = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        branch      = 1'b0;
        branch_jump = 1'b0;
        imm         = '0;
        rs1         = '0;
        trap        = 1'b0;
        trap_vec    = '0;
        halt        = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_trap(input logic [31:0] vec);
        clr();
        trap     = 1'b1;
        trap_vec = vec;
        tick();
        clr();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        fetch_ready = 1'b1;
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_a, 32'h8000_0000);
        chk("rst_fv", fv_a, 1'b0);
        chk("rst_instret", ir_a, 64'd0);
        chk("rst_redirect", red_a, 1'b0);
        chk("rst_misalign", mis_a, 1'b0);
        chk("rst_maddr", maddr_a, 32'd0);
        rst = 1'b0;

        tick();
        chk("fv_edge1", fv_a, 1'b0);
        tick();
        chk("fv_edge2", fv_a, 1'b1);
        chk("pc_before_run", pc_a, 32'h8000_0000);

        exec_valid = 1'b1;
        tick();
        chk("seq_pc1", pc_a, 32'h8000_0004);
        chk("seq_red1", red_a, 1'b0);
        tick();
        chk("seq_pc2", pc_a, 32'h8000_0008);
        chk("seq_red2", red_a, 1'b0);
        tick();
        chk("seq_pc3", pc_a, 32'h8000_000C);
        chk("seq_red3", red_a, 1'b0);
        chk("seq_instret", ir_a, 64'd3);
        clr();

        do_trap(32'h0000_0100);
        chk("trap100_pc", pc_a, 32'h100);
        chk("trap100_red", red_a, 1'b1);
        exec_valid  = 1'b1;
        branch      = 1'b1;
        branch_jump = 1'b1;
        imm         = 32'hFFFF_FFF0;
        tick();
        chk("br_taken_pc", pc_a, 32'hF0);
        chk("br_taken_red", red_a, 1'b1);
        chk("br_taken_ir", ir_a, 64'd4);
        clr();
        tick();
        chk("br_red_once", red_a, 1'b0);
        chk("br_pc_hold", pc_a, 32'hF0);

        do_trap(32'h0000_0100);
        exec_valid = 1'b1;
        branch     = 1'b1;
        imm        = 32'hFFFF_FFF0;
        tick();
        chk("br_nt_pc", pc_a, 32'h104);
        chk("br_nt_red", red_a, 1'b0);
        chk("br_nt_ir", ir_a, 64'd5);
        clr();

        do_trap(32'h0000_2000);
        exec_valid = 1'b1;
        jalr       = 1'b1;
        rs1        = 32'h2001;
        imm        = 32'h4;
        tick();
        chk("jalr_b_pc", pc_b, 32'h2004);
        chk("jalr_a_pc", pc_a, 32'h2004);
        chk("jalr_a_ir", ir_a, 64'd6);
        rs1 = 32'h2003;
        imm = 32'h0;
        tick();
        chk("mis_pulse", mis_a, 1'b1);
        chk("mis_addr", maddr_a, 32'h2002);
        chk("mis_pc_hold", pc_a, 32'h2004);
        chk("mis_ir", ir_a, 64'd6);
        chk("mis_red", red_a, 1'b0);
        chk("mis_b_pc", pc_b, 32'h2002);
        chk("mis_b_none", mis_b, 1'b0);
        clr();
        tick();
        chk("mis_drop", mis_a, 1'b0);
        chk("mis_addr_held", maddr_a, 32'h2002);

        exec_valid = 1'b1;
        stall      = 1'b1;
        trap       = 1'b1;
        trap_vec   = 32'h1003;
        tick();
        chk("stl_trap_pc", pc_a, 32'h1000);
        chk("stl_trap_red", red_a, 1'b1);
        chk("stl_trap_ir", ir_a, 64'd6);
        chk("stl_trap_b_pc", pc_b, 32'h1002);
        clr();

        exec_valid = 1'b1;
        halt       = 1'b1;
        tick();
        chk("halt_pc", pc_a, 32'h1004);
        chk("halt_fv", fv_a, 1'b0);
        chk("halt_ir", ir_a, 64'd7);
        clr();
        exec_valid = 1'b1;
        tick();
        chk("halt_ign_pc", pc_a, 32'h1004);
        chk("halt_ign_ir", ir_a, 64'd7);
        chk("halt_ign_fv", fv_a, 1'b0);
        clr();
        resume = 1'b1;
        tick();
        chk("resume_fv", fv_a, 1'b1);
        chk("resume_pc", pc_a, 32'h1004);
        clr();

        do_trap(32'hFFFF_FFFC);
        exec_valid = 1'b1;
        jal        = 1'b1;
        imm        = 32'h8;
        tick();
        chk("wrap_pc", pc_a, 32'h4);
        chk("wrap_red", red_a, 1'b1);
        chk("wrap_ir", ir_a, 64'd8);
        clr();

        #3;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc_a, 32'h8000_0000);
        chk("arst_ir", ir_a, 64'd0);
        chk("arst_fv", fv_a, 1'b0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
